// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: FIFO-buffered job launcher and result holder for the subtract-and-compare GCD core.
// Optional WAIT watchdog is compiled in when GCD_TIMEOUT_EN is defined.
module gcd_job_sequencer #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gcd,
  output logic                     out_err,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_data,
  input  logic                     core_done,
  input  logic [WIDTH-1:0]         core_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    BYPASS = 3'd5
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] job_a, job_b;
  logic             full, empty, push, pop;
  logic             done_hit, timeout_hit;
  logic             start_d, busy_d;
  logic [WIDTH-1:0] data_d;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == {(AW+1){1'b0}});
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // A job is only taken once the previous result has been consumed.
  assign pop      = (state == IDLE) && !empty && !out_valid;
  assign done_hit = (state == WAIT) && core_done;

`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= {CW{1'b0}};
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + CW'(1);
    end else begin
      wd_cnt <= {CW{1'b0}};
    end
  end

  assign timeout_hit = (state == WAIT) && !core_done && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      level  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (!push && pop) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job_a <= ZERO;
      job_b <= ZERO;
    end else if (pop) begin
      job_a <= mem_a[rd_ptr];
      job_b <= mem_b[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pop) begin
          if ((mem_a[rd_ptr] == ZERO) || (mem_b[rd_ptr] == ZERO)) next_state = BYPASS;
          else                                                     next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      START:  next_state = LOAD_A;
      LOAD_A: next_state = LOAD_B;
      LOAD_B: next_state = WAIT;
      WAIT: begin
        if (done_hit || timeout_hit) next_state = IDLE;
        else                         next_state = WAIT;
      end
      BYPASS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Core-side outputs are decoded from next_state so the registered copies line up with state.
  always_comb begin
    start_d = 1'b0;
    data_d  = ZERO;
    busy_d  = (next_state != IDLE);
    case (next_state)
      START:  start_d = 1'b1;
      LOAD_A: data_d  = job_a;
      LOAD_B: data_d  = job_b;
      default: begin
        start_d = 1'b0;
        data_d  = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_start <= 1'b0;
      core_data  <= ZERO;
      busy       <= 1'b0;
    end else begin
      core_start <= start_d;
      core_data  <= data_d;
      busy       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gcd   <= ZERO;
      out_err   <= 1'b0;
    end else if (state == BYPASS) begin
      out_gcd   <= (job_a == ZERO) ? job_b : job_a;
      out_valid <= 1'b1;
      out_err   <= 1'b0;
    end else if (done_hit) begin
      out_gcd   <= core_result;
      out_valid <= 1'b1;
      out_err   <= 1'b0;
    end else if (timeout_hit) begin
      out_gcd   <= ZERO;
      out_valid <= 1'b1;
      out_err   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed self-checking bench for gcd_job_sequencer with a behavioural subtract-and-compare core.
// The watchdog scenario is included when GCD_TIMEOUT_EN is defined.
module tb_gcd_job_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid, out_err, core_start, busy;
  logic [W-1:0] in_a, in_b, out_gcd, core_data;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = 16'd0;
  logic [2:0]   level;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  gcd_job_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_err(out_err), .core_start(core_start),
    .core_data(core_data), .core_done(core_done), .core_result(core_result),
    .busy(busy), .level(level)
  );

  // Behavioural core: captures A then B after start, subtracts until equal, pulses done.
  int           m_state = 0;
  logic [W-1:0] ma = 16'd0, mb = 16'd0;
  logic         stall = 1'b0, inject = 1'b0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) m_state = 0;
    else if (core_start) m_state = 1;
    else begin
      case (m_state)
        1: begin ma = core_data; m_state = 2; end
        2: begin mb = core_data; m_state = 3; end
        3: if (!stall) begin
             if (ma == mb) begin core_result = ma; core_done = 1'b1; m_state = 0; end
             else if (ma > mb) ma = ma - mb;
             else mb = mb - ma;
           end
        default: ;
      endcase
    end
    if (inject) begin core_done = 1'b1; core_result = 16'd25; end
  end

  task test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_gcd !== 16'd0) begin n_bad++; $display("FAIL reset_out_gcd: got %0d want 0", out_gcd); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    n_cmp++; if (core_data !== 16'd0) begin n_bad++; $display("FAIL reset_core_data: got %0d want 0", core_data); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task test_basic;
    int starts;
    bit got;
    out_ready = 1'b1; in_a = 16'd12; in_b = 16'd18; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL basic_level_push: got %0d want 1", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL basic_start: got %b want 1", core_start); end
    n_cmp++; if (core_data !== 16'd0) begin n_bad++; $display("FAIL basic_data_start: got %0d want 0", core_data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL basic_level_pop: got %0d want 0", level); end
    @(negedge clk);
    n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL basic_start_pulse: got %b want 0", core_start); end
    n_cmp++; if (core_data !== 16'd12) begin n_bad++; $display("FAIL basic_data_a: got %0d want 12", core_data); end
    @(negedge clk);
    n_cmp++; if (core_data !== 16'd18) begin n_bad++; $display("FAIL basic_data_b: got %0d want 18", core_data); end
    @(negedge clk);
    n_cmp++; if (core_data !== 16'd0) begin n_bad++; $display("FAIL basic_data_wait: got %0d want 0", core_data); end
    starts = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (core_start) starts++;
      if (out_valid) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_result_timeout: got %b want 1", got); end
    n_cmp++; if (out_gcd !== 16'd6) begin n_bad++; $display("FAIL basic_gcd: got %0d want 6", out_gcd); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", out_err); end
    @(negedge clk);
    if (core_start) starts++;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_one_cycle: got %b want 0", out_valid); end
    n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL basic_extra_start: got %0d want 0", starts); end
  endtask

  task test_bypass;
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] te [3];
    int n, starts;
    bit got;
    ta = '{16'd0, 16'd9, 16'd0};
    tb = '{16'd7, 16'd0, 16'd0};
    te = '{16'd7, 16'd9, 16'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = ta[i]; in_b = tb[i]; in_valid = 1'b1;
      n = 0; starts = 0; got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk); in_valid = 1'b0; n++;
        if (core_start) starts++;
        if (out_valid) got = 1'b1;
      end
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bypass_result_%0d: got %b want 1", i, got); end
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL bypass_latency_%0d: got %0d want 3", i, n); end
      n_cmp++; if (out_gcd !== te[i]) begin n_bad++; $display("FAIL bypass_gcd_%0d: got %0d want %0d", i, out_gcd, te[i]); end
      n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL bypass_start_%0d: got %0d want 0", i, starts); end
    end
    @(negedge clk);
  endtask

  task test_back_to_back;
    logic [W-1:0] ja [5];
    logic [W-1:0] jb [5];
    logic [W-1:0] je [5];
    int idx, starts;
    bit got;
    ja = '{16'd48, 16'd7, 16'd0, 16'd21, 16'd8};
    jb = '{16'd36, 16'd5, 16'd9, 16'd14, 16'd8};
    je = '{16'd12, 16'd1, 16'd9, 16'd7, 16'd8};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
      in_a = ja[i]; in_b = jb[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_a = 16'd99; in_b = 16'd3;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL b2b_level_full: got %0d want 4", level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); end
    got = 1'b0; starts = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_first_result: got %b want 1", got); end
    repeat (6) begin
      @(negedge clk);
      if (core_start) starts++;
    end
    n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL b2b_start_while_held: got %0d want 0", starts); end
    n_cmp++; if (out_gcd !== 16'd12) begin n_bad++; $display("FAIL b2b_held_gcd: got %0d want 12", out_gcd); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL b2b_level_held: got %0d want 4", level); end
    in_valid = 1'b0; out_ready = 1'b1; idx = 0;
    for (int c = 0; c < 400 && idx < 5; c++) begin
      if (out_valid) begin
        n_cmp++; if (out_gcd !== je[idx]) begin n_bad++; $display("FAIL b2b_order_%0d: got %0d want %0d", idx, out_gcd, je[idx]); end
        idx++;
      end
      @(negedge clk);
    end
    n_cmp++; if (idx !== 5) begin n_bad++; $display("FAIL b2b_result_count: got %0d want 5", idx); end
    repeat (10) @(negedge clk);
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL b2b_level_drained: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  task test_reset_mid_job;
    bit seen;
    logic [W-1:0] ra [3];
    logic [W-1:0] rb [3];
    ra = '{16'd100, 16'd6, 16'd10};
    rb = '{16'd75, 16'd4, 16'd5};
    out_ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = ra[i]; in_b = rb[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_wait: got %b want 1", busy); end
    n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL rstmid_level_queued: got %0d want 2", level); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    @(posedge clk); inject = 1'b1;
    @(posedge clk); inject = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_done: got %b want 0", seen); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
  endtask

`ifdef GCD_TIMEOUT_EN
  task test_timeout;
    int n;
    bit got;
    out_ready = 1'b0; stall = 1'b1;
    in_a = 16'd30; in_b = 16'd12; in_valid = 1'b1;
    n = 0; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk); in_valid = 1'b0; n++;
      if (out_valid) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL timeout_valid: got %b want 1", got); end
    n_cmp++; if (n !== 21) begin n_bad++; $display("FAIL timeout_latency: got %0d want 21", n); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", out_err); end
    n_cmp++; if (out_gcd !== 16'd0) begin n_bad++; $display("FAIL timeout_gcd: got %0d want 0", out_gcd); end
    stall = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_a = 16'd30; in_b = 16'd12; in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk); in_valid = 1'b0;
      if (out_valid) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL timeout_next_valid: got %b want 1", got); end
    n_cmp++; if (out_gcd !== 16'd6) begin n_bad++; $display("FAIL timeout_next_gcd: got %0d want 6", out_gcd); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL timeout_next_err: got %b want 0", out_err); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_back_to_back();
    test_reset_mid_job();
`ifdef GCD_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
